bsg_unconcentrate_dynamic: RTL and testbench

BSG_UNCONCENTRATE_DYNAMIC -- requirements
Module: bsg_unconcentrate_dynamic

---
 rtl/bsg_unconcentrate_dynamic_if.sv | 30 +++
 rtl/bsg_unconcentrate_dynamic.sv | 95 +++++++++
 tb/tb_bsg_unconcentrate_dynamic.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/bsg_unconcentrate_dynamic_if.sv
// Valid/ready handshake bundle for bsg_unconcentrate_dynamic.
// Member names take the block's point of view (the block drives the *_o members).
interface bsg_unconcentrate_dynamic_if #(
  parameter int unsigned els_p = 32
);
  logic             v_i;
  logic [els_p-1:0] data_i;
  logic             ready_o;
  logic             v_o;
  logic [els_p-1:0] data_o;
  logic             ready_i;

  modport slave (
    input  v_i,
    input  data_i,
    input  ready_i,
    output ready_o,
    output v_o,
    output data_o
  );

  modport master (
    output v_i,
    output data_i,
    output ready_i,
    input  ready_o,
    input  v_o,
    input  data_o
  );
endinterface

// File: rtl/bsg_unconcentrate_dynamic.sv
// Expands a compacted input word onto the lanes selected by a run-time pattern register,
// behind a single registered valid/ready output stage.
module bsg_unconcentrate_dynamic #(
  parameter int unsigned els_p           = 32,
  parameter logic [63:0] reset_pattern_p = 64'h0000_0000_EDBF_EDB9,
  parameter bit          hold_p          = 1'b0,
  parameter logic        fill_p          = 1'b0
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         cfg_v_i,
  input  logic [els_p-1:0]             cfg_pattern_i,
  output logic [$clog2(els_p+1)-1:0]   lanes_o,
  bsg_unconcentrate_dynamic_if.slave   bus
);

  localparam int unsigned LanesW = $clog2(els_p + 1);

  function automatic logic [LanesW-1:0] popcount(input logic [els_p-1:0] vec);
    logic [LanesW-1:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < els_p; i++) begin
      cnt = cnt + LanesW'(vec[i]);
    end
    return cnt;
  endfunction

  localparam logic [els_p-1:0]  ResetPattern = reset_pattern_p[els_p-1:0];
  localparam logic [LanesW-1:0] ResetLanes   = popcount(ResetPattern);

  logic [els_p-1:0]  pattern_q, pattern_d;
  logic [LanesW-1:0] lanes_q, lanes_d;
  logic [els_p-1:0]  data_q, data_d;
  logic              v_q, v_d;
  logic              in_fire, out_fire;
  logic [els_p-1:0]  remaining;

  assign bus.ready_o = ~v_q | bus.ready_i;
  assign in_fire     = bus.v_i & bus.ready_o;
  assign out_fire    = v_q & bus.ready_i;

  // Populated lanes consume input bits in ascending order; the current (old) pattern
  // applies even when a pattern write lands in the same cycle.
  always_comb begin
    data_d    = data_q;
    remaining = bus.data_i;
    for (int unsigned j = 0; j < els_p; j++) begin
      if (pattern_q[j]) begin
        data_d[j] = remaining[0];
        remaining = remaining >> 1;
      end else if (!hold_p) begin
        data_d[j] = fill_p;
      end
    end
  end

  always_comb begin
    v_d = v_q;
    if (in_fire) begin
      v_d = 1'b1;
    end else if (out_fire) begin
      v_d = 1'b0;
    end
  end

  always_comb begin
    pattern_d = pattern_q;
    lanes_d   = lanes_q;
    if (cfg_v_i) begin
      pattern_d = cfg_pattern_i;
      lanes_d   = popcount(cfg_pattern_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      v_q       <= 1'b0;
      data_q    <= '0;
      pattern_q <= ResetPattern;
      lanes_q   <= ResetLanes;
    end else begin
      v_q       <= v_d;
      pattern_q <= pattern_d;
      lanes_q   <= lanes_d;
      if (in_fire) begin
        data_q <= data_d;
      end
    end
  end

  assign bus.v_o    = v_q;
  assign bus.data_o = data_q;
  assign lanes_o    = lanes_q;

endmodule

// File: tb/tb_bsg_unconcentrate_dynamic.sv
// Directed plus randomized bench for bsg_unconcentrate_dynamic (els_p=32), driving a
// fill instance and a hold instance in lockstep against a rank-based reference model.
module tb_bsg_unconcentrate_dynamic;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cfg_v;
  logic [31:0] cfg_pattern;
  logic        v_in;
  logic [31:0] data_in;
  logic        rdy_in;
  logic [5:0]  lanes0, lanes1;

  int checks   = 0;
  int failures = 0;

  logic        exp_v;
  logic [31:0] exp_pat;
  logic [31:0] exp_d0, exp_d1;

  always #5 clk = ~clk;

  bsg_unconcentrate_dynamic_if #(.els_p(32)) bus0 ();
  bsg_unconcentrate_dynamic_if #(.els_p(32)) bus1 ();

  assign bus0.v_i     = v_in;
  assign bus0.data_i  = data_in;
  assign bus0.ready_i = rdy_in;
  assign bus1.v_i     = v_in;
  assign bus1.data_i  = data_in;
  assign bus1.ready_i = rdy_in;

  bsg_unconcentrate_dynamic #(.els_p(32), .hold_p(1'b0)) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .cfg_v_i      (cfg_v),
    .cfg_pattern_i(cfg_pattern),
    .lanes_o      (lanes0),
    .bus          (bus0)
  );

  bsg_unconcentrate_dynamic #(.els_p(32), .hold_p(1'b1)) dut_h (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .cfg_v_i      (cfg_v),
    .cfg_pattern_i(cfg_pattern),
    .lanes_o      (lanes1),
    .bus          (bus1)
  );

  // Lane j takes input bit rank(j) = number of populated lanes below j.
  function automatic logic [31:0] model_expand(input logic [31:0] pat, input logic [31:0] d,
                                               input bit hold, input logic [31:0] prev);
    logic [31:0] out;
    logic [31:0] below;
    int          r;
    for (int j = 0; j < 32; j++) begin
      below = (j == 0) ? 32'h0 : ((32'h1 << j) - 32'h1);
      r     = $countones(pat & below);
      if (pat[j])    out[j] = d[r];
      else if (hold) out[j] = prev[j];
      else           out[j] = 1'b0;
    end
    return out;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".v0"},     64'(bus0.v_o),    64'(exp_v));
    check({tag, ".v1"},     64'(bus1.v_o),    64'(exp_v));
    check({tag, ".data0"},  64'(bus0.data_o), 64'(exp_d0));
    check({tag, ".data1"},  64'(bus1.data_o), 64'(exp_d1));
    check({tag, ".lanes0"}, 64'(lanes0),      64'($countones(exp_pat)));
    check({tag, ".lanes1"}, 64'(lanes1),      64'($countones(exp_pat)));
  endtask

  // One clock: drive inputs, check ready before the edge, advance model, check after.
  task automatic cycle(input string tag, input logic cv, input logic [31:0] cp,
                       input logic vi, input logic [31:0] di, input logic ri);
    logic exp_ready;
    cfg_v = cv; cfg_pattern = cp; v_in = vi; data_in = di; rdy_in = ri;
    #1;
    exp_ready = !exp_v || ri;
    check({tag, ".ready0"}, 64'(bus0.ready_o), 64'(exp_ready));
    check({tag, ".ready1"}, 64'(bus1.ready_o), 64'(exp_ready));
    @(posedge clk);
    if (vi && exp_ready) begin
      exp_d0 = model_expand(exp_pat, di, 1'b0, exp_d0);
      exp_d1 = model_expand(exp_pat, di, 1'b1, exp_d1);
      exp_v  = 1'b1;
    end else if (exp_v && ri) begin
      exp_v = 1'b0;
    end
    if (cv) exp_pat = cp;
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    cfg_v = 1'b1; cfg_pattern = $urandom; v_in = 1'b1; data_in = $urandom; rdy_in = 1'b0;
    repeat (2) @(posedge clk);
    exp_v = 1'b0; exp_d0 = '0; exp_d1 = '0; exp_pat = 32'hEDBF_EDB9;
    #1;
    check_outputs(tag);
    check({tag, ".lanes_const"}, 64'(lanes0), 64'd24);
    reset_n = 1'b1;
    cfg_v = 1'b0; v_in = 1'b0; rdy_in = 1'b0;
  endtask

  initial begin
    logic [31:0] w [4];
    reset_n = 1'b0; cfg_v = 1'b0; cfg_pattern = '0; v_in = 1'b0; data_in = '0; rdy_in = 1'b0;
    exp_v = 1'b0; exp_pat = 32'hEDBF_EDB9; exp_d0 = '0; exp_d1 = '0;
    @(posedge clk);
    #1;
    do_reset("reset");

    // Basic expansion with the reset pattern.
    cycle("req032", 1'b0, '0, 1'b1, 32'h00FF_FFFF, 1'b1);
    check("req032.const", 64'(bus0.data_o), 64'h0000_0000_EDBF_EDB9);
    cycle("req033a", 1'b0, '0, 1'b1, 32'h0080_0000, 1'b1);
    check("req033a.const", 64'(bus0.data_o), 64'h8000_0000);
    cycle("req033b", 1'b0, '0, 1'b1, 32'h0000_0001, 1'b1);
    check("req033b.const", 64'(bus0.data_o), 64'h1);
    cycle("req033c", 1'b0, '0, 1'b1, 32'hFF00_0000, 1'b1);
    check("req033c.const", 64'(bus0.data_o), 64'h0);

    // Backpressure: output must hold while ready_i is low, then stream in order.
    for (int i = 0; i < 4; i++) w[i] = $urandom;
    cycle("bp_load", 1'b0, '0, 1'b1, w[0], 1'b0);
    for (int i = 0; i < 3; i++) cycle("bp_stall", 1'b0, '0, 1'b1, w[1], 1'b0);
    for (int i = 1; i < 4; i++) cycle("bp_stream", 1'b0, '0, 1'b1, w[i], 1'b1);
    cycle("bp_drain", 1'b0, '0, 1'b0, '0, 1'b1);

    // Pattern write coincident with a transfer uses the old pattern for that word.
    cycle("req035a", 1'b1, 32'h0000_000F, 1'b1, 32'h00FF_FFFF, 1'b1);
    check("req035a.const", 64'(bus0.data_o), 64'h0000_0000_EDBF_EDB9);
    cycle("req035b", 1'b0, '0, 1'b1, 32'h0000_0005, 1'b1);
    check("req035b.const", 64'(bus0.data_o), 64'h5);
    check("req035b.lanes", 64'(lanes0), 64'd4);

    // Hold instance keeps unpopulated lanes; pattern writes never touch held data.
    cycle("req036a", 1'b1, 32'hFFFF_FFFF, 1'b0, '0, 1'b1);
    cycle("req036b", 1'b0, '0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    cycle("req036c", 1'b1, 32'h0000_00FF, 1'b0, '0, 1'b0);
    cycle("req036d", 1'b0, '0, 1'b0, '0, 1'b1);
    cycle("req036e", 1'b0, '0, 1'b1, 32'h0000_0000, 1'b1);
    check("req036.const", 64'(bus1.data_o), 64'hFFFF_FF00);

    // All-zero pattern: handshake still completes.
    cycle("zero_cfg", 1'b1, 32'h0, 1'b0, '0, 1'b1);
    cycle("zero_data", 1'b0, '0, 1'b1, $urandom, 1'b1);
    check("zero.const", 64'(bus0.data_o), 64'h0);

    // Randomized traffic with occasional pattern writes.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] pat;
      int sel;
      sel = $urandom_range(0, 9);
      pat = (sel == 0) ? 32'hFFFF_FFFF : (sel == 1) ? 32'h0 : $urandom;
      cycle("rand", ($urandom_range(0, 7) == 0), pat, 1'($urandom), $urandom,
            ($urandom_range(0, 3) != 0));
    end

    // Reset while a word is stalled in the output register.
    cycle("req037_load", 1'b1, 32'h1234_5678, 1'b1, $urandom, 1'b0);
    cycle("req037_hold", 1'b0, '0, 1'b1, $urandom, 1'b0);
    do_reset("req037");
    check("req037.v_const", 64'(bus0.v_o), 64'h0);
    cycle("post_reset_idle", 1'b0, '0, 1'b0, $urandom, 1'b1);
    cycle("post_reset_xfer", 1'b0, '0, 1'b1, 32'h00FF_FFFF, 1'b1);
    check("post_reset.const", 64'(bus0.data_o), 64'h0000_0000_EDBF_EDB9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
